lcd_byte_writer: RTL and testbench
==================================

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, sets RS/data setup cycles before each enable pulse.
REQ-002 Parameter ENABLE_CYCLES, default 12, sets oLCD_Enabled high time per nibble.
REQ-003 Parameter NIBBLE_GAP_CYCLES, default 50, sets cycles between the high-nibble and low-nibble pulses (1 us at 50 MHz).
REQ-004 Parameter CMD_WAIT_CYCLES, default 2000, sets post-byte wait (40 us).
REQ-005 Parameter CLEAR_WAIT_CYCLES, default 82000, sets post-byte wait for clear/home commands (1.64 ms).
REQ-006 All parameters SHALL be >= 1.
REQ-007 Clock  input  1  single system clock, all state on rising edge.
REQ-008 Reset  input  1  asynchronous, active-low reset.
REQ-009 iData  input  8  byte to write.
REQ-010 iRegisterSelect  input  1  0=command, 1=data.
REQ-011 iValid  input  1  byte request.
REQ-012 oReady  output  1  high only in IDLE; a byte is accepted on a rising edge with iValid=1 and oReady=1.
REQ-013 oDone  output  1  one-cycle pulse on completion of a byte.
REQ-014 oLCD_Enabled  output  1  LCD E strobe.
REQ-015 oLCD_RegisterSelect  output  1  LCD RS.
REQ-016 oLCD_Data  output  4  LCD DB7..DB4.
REQ-017 oLCD_ReadWrite  output  1  tied to 0 (write-only).

Function
REQ-018 All outputs SHALL be registered; the FSM states are IDLE, HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, WAIT.
REQ-019 On acceptance, iData and iRegisterSelect SHALL be latched; later input changes have no effect until the next acceptance.
REQ-020 Numbering cycles from the accepting edge (cycle 0), with default parameters: HI_SETUP cycles 0-1; HI_PULSE cycles 2-13 with E=1; GAP cycles 14-63; LO_SETUP cycles 64-65; LO_PULSE cycles 66-77 with E=1; WAIT cycles 78-2077; IDLE from cycle 2078 with oReady=1.
REQ-021 oLCD_Data SHALL be iData[7:4] from HI_SETUP through GAP, and iData[3:0] from LO_SETUP through WAIT.
REQ-022 oLCD_RegisterSelect SHALL equal the latched RS from HI_SETUP through WAIT; it is 0 in IDLE.
REQ-023 oLCD_Enabled SHALL be 1 only in HI_PULSE and LO_PULSE, for exactly ENABLE_CYCLES consecutive cycles each.
REQ-024 oDone SHALL be 1 for exactly the first IDLE cycle after WAIT.
REQ-025 iValid=1 in that same cycle SHALL be accepted, giving back-to-back bytes with no extra gap.
REQ-026 iValid while oReady=0 SHALL be ignored; there is no buffering and no error flag.
REQ-027 The wait counter SHALL be 32 bits and SHALL clear on every state transition; each timed state lasts exactly its parameter value in cycles.
REQ-028 In IDLE, oLCD_Data SHALL hold its last value and E SHALL be 0.

Reset
REQ-029 Reset=0 SHALL immediately, without a clock, force the state to IDLE and the outputs to oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oDone=0, with the counter and latches cleared.
REQ-030 oReady SHALL be 0 while Reset=0 and 1 from the first rising edge after release.
REQ-031 Reset asserted mid-byte SHALL abort the transfer, drop E the same instant, and produce no oDone.

Configuration
REQ-032 Macro LCD_BUSY_EXTEND_EN: when defined, a command (RS=0) with iData 8'h01, 8'h02 or 8'h03 SHALL use CLEAR_WAIT_CYCLES in WAIT.
REQ-033 Without LCD_BUSY_EXTEND_EN, every byte SHALL use CMD_WAIT_CYCLES, and CLEAR_WAIT_CYCLES SHALL be unused.

Verification
REQ-034 Write 8'h28, RS=0, default parameters -> E high in cycles 2-13 with data 4'h2 and in cycles 66-77 with data 4'h8, RS=0, oDone in cycle 2078.
REQ-035 Write 8'h41, RS=1, then hold iValid with 8'h42 -> the second byte is accepted in the oDone cycle of the first, and its E pulse starts 2 cycles later.
REQ-036 Pulse iValid with 8'hFF at cycle 30 of a transfer of 8'h0C -> ignored; only 8'h0C appears on the bus (4'h0 then 4'hC).
REQ-037 Write 8'h01, RS=0 -> oDone at cycle 82078 with LCD_BUSY_EXTEND_EN defined, and at cycle 2078 without it.
REQ-038 Assert Reset=0 asynchronously at cycle 5 (mid HI_PULSE) -> E=0 and data=0 before the next edge, no oDone, and oReady=1 on the first edge after release.

Source files
------------

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780-style LCD as two 4-bit nibbles with timed E strobes.
// Optional macro LCD_BUSY_EXTEND_EN: clear/home commands (8'h01..8'h03, RS=0) use CLEAR_WAIT_CYCLES.
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYCLES      = 32'd2,
  parameter int unsigned ENABLE_CYCLES     = 32'd12,
  parameter int unsigned NIBBLE_GAP_CYCLES = 32'd50,
  parameter int unsigned CMD_WAIT_CYCLES   = 32'd2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 32'd82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_ReadWrite
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HI_SETUP = 3'd1,
    HI_PULSE = 3'd2,
    GAP      = 3'd3,
    LO_SETUP = 3'd4,
    LO_PULSE = 3'd5,
    WAIT     = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_lo;
  logic        r_ready;
  logic        r_done;
  logic        r_en;
  logic        r_rs;
  logic [3:0]  r_data;
  logic [31:0] w_wait_len;
  logic [31:0] w_len;
  logic        w_last;

`ifdef LCD_BUSY_EXTEND_EN
  logic r_long_wait;
  assign w_wait_len = r_long_wait ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
`else
  logic w_unused_clear;
  assign w_wait_len     = CMD_WAIT_CYCLES;
  assign w_unused_clear = (CLEAR_WAIT_CYCLES != 32'd0);
`endif

  // Duration of the current timed state.
  always_comb begin
    w_len = 32'd1;
    case (r_state)
      HI_SETUP, LO_SETUP: w_len = SETUP_CYCLES;
      HI_PULSE, LO_PULSE: w_len = ENABLE_CYCLES;
      GAP:                w_len = NIBBLE_GAP_CYCLES;
      WAIT:               w_len = w_wait_len;
      default:            w_len = 32'd1;
    endcase
  end

  assign w_last = (r_cnt == (w_len - 32'd1));

  // Sequencer: state, cycle counter, latched byte and all registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 32'd0;
      r_lo    <= 4'd0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 4'd0;
`ifdef LCD_BUSY_EXTEND_EN
      r_long_wait <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= 32'd0;
          if (r_ready && iValid) begin
            r_state <= HI_SETUP;
            r_ready <= 1'b0;
            r_data  <= iData[7:4];
            r_lo    <= iData[3:0];
            r_rs    <= iRegisterSelect;
`ifdef LCD_BUSY_EXTEND_EN
            r_long_wait <= !iRegisterSelect &&
                           ((iData == 8'h01) || (iData == 8'h02) || (iData == 8'h03));
`endif
          end else begin
            // Also raises ready on the first edge after reset release.
            r_ready <= 1'b1;
          end
        end
        HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, WAIT: begin
          if (w_last) begin
            r_cnt <= 32'd0;
            case (r_state)
              HI_SETUP: begin r_state <= HI_PULSE; r_en <= 1'b1; end
              HI_PULSE: begin r_state <= GAP;      r_en <= 1'b0; end
              GAP:      begin r_state <= LO_SETUP; r_data <= r_lo; end
              LO_SETUP: begin r_state <= LO_PULSE; r_en <= 1'b1; end
              LO_PULSE: begin r_state <= WAIT;     r_en <= 1'b0; end
              WAIT: begin
                r_state <= IDLE;
                r_ready <= 1'b1;
                r_done  <= 1'b1;
                r_rs    <= 1'b0;
              end
              default: r_state <= IDLE;
            endcase
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 32'd0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign oReady              = r_ready;
  assign oDone               = r_done;
  assign oLCD_Enabled        = r_en;
  assign oLCD_RegisterSelect = r_rs;
  assign oLCD_Data           = r_data;
  assign oLCD_ReadWrite      = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Scoreboard bench for lcd_byte_writer: expected E pulses and oDone events are queued
// when a byte is driven and compared against events captured by a bus monitor.
module tb_lcd_byte_writer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] iData = 8'd0;
  logic       iRegisterSelect = 1'b0;
  logic       iValid = 1'b0;
  logic       oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  lcd_byte_writer dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iRegisterSelect(iRegisterSelect),
    .iValid(iValid), .oReady(oReady), .oDone(oDone), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_Data(oLCD_Data),
    .oLCD_ReadWrite(oLCD_ReadWrite)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  kind;   // 0 = E pulse, 1 = done
    logic [3:0]  data;
    logic        rs;
    logic        stable;
    logic [31:0] cyc;
    logic [31:0] len;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  tests = 0;
  int  fails = 0;

  // Bus monitor: one event per completed E pulse and per cycle with oDone high.
  initial begin
    logic       prev_e;
    int         st;
    logic [3:0] sd;
    logic       sr, sstab;
    ev_t        e;
    prev_e = 1'b0; st = 0; sd = 4'd0; sr = 1'b0; sstab = 1'b0;
    forever begin
      @(negedge Clock);
      if (oLCD_Enabled && !prev_e) begin
        st = cyc; sd = oLCD_Data; sr = oLCD_RegisterSelect; sstab = 1'b1;
      end else if (oLCD_Enabled && ((oLCD_Data !== sd) || (oLCD_RegisterSelect !== sr))) begin
        sstab = 1'b0;
      end
      if (!oLCD_Enabled && prev_e) begin
        e.kind = 2'd0; e.data = sd; e.rs = sr; e.stable = sstab;
        e.cyc = 32'(st); e.len = 32'(cyc - st);
        obs_q.push_back(e);
      end
      if (oDone === 1'b1) begin
        e.kind = 2'd1; e.data = 4'd0; e.rs = 1'b0; e.stable = 1'b0;
        e.cyc = 32'(cyc); e.len = 32'd0;
        obs_q.push_back(e);
      end
      prev_e = oLCD_Enabled;
    end
  end

  function automatic int exp_wait(input logic [7:0] d, input logic rs);
`ifdef LCD_BUSY_EXTEND_EN
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return 82000;
`endif
    return 2000;
  endfunction

  function automatic void push_byte(input int a, input logic [7:0] d, input logic rs);
    ev_t e;
    e = '{kind: 2'd0, data: d[7:4], rs: rs, stable: 1'b1, cyc: 32'(a + 2),  len: 32'd12};
    exp_q.push_back(e);
    e = '{kind: 2'd0, data: d[3:0], rs: rs, stable: 1'b1, cyc: 32'(a + 66), len: 32'd12};
    exp_q.push_back(e);
    e = '{kind: 2'd1, data: 4'd0, rs: 1'b0, stable: 1'b0, cyc: 32'(a + 78 + exp_wait(d, rs)), len: 32'd0};
    exp_q.push_back(e);
  endfunction

  // Waits for oReady (bounded), presents a byte and returns the accepting cycle.
  task automatic send_byte(input logic [7:0] d, input logic rs, input bit hold, output int a);
    int n = 0;
    @(negedge Clock);
    while (oReady !== 1'b1 && n < 100) begin @(negedge Clock); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_ready_timeout: got oReady=%b, expected 1 within 100 cycles", oReady);
    end
    iData = d; iRegisterSelect = rs; iValid = 1'b1;
    @(posedge Clock); #1;
    a = cyc;
    if (!hold) iValid = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) @(negedge Clock);
    @(negedge Clock); #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    tests++;
    if ({oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_ReadWrite} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b done=%b e=%b rs=%b d=%h rw=%b, expected all 0",
               oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_ReadWrite);
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    tests++;
    if (oReady !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after_release: got %b, expected 1", oReady);
    end
    obs_q.delete();
  endtask

  task automatic test_write_28;
    int a; ev_t e, o;
    send_byte(8'h28, 1'b0, 1'b0, a);
    push_byte(a, 8'h28, 1'b0);
    tests++;
    if (oReady !== 1'b0 || oLCD_Data !== 4'h2) begin
      fails++; $display("FAIL w28_accept: got rdy=%b d=%h, expected rdy=0 d=2", oReady, oLCD_Data);
    end
    run_until(a + 2078);
    tests++;
    if (oReady !== 1'b1 || oLCD_Data !== 4'h8 || oLCD_Enabled !== 1'b0 || oLCD_RegisterSelect !== 1'b0) begin
      fails++;
      $display("FAIL w28_idle_hold: got rdy=%b d=%h e=%b rs=%b, expected rdy=1 d=8 e=0 rs=0",
               oReady, oLCD_Data, oLCD_Enabled, oLCD_RegisterSelect);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL w28_event: got none, expected kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL w28_event: got k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d, expected k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d",
                   o.kind, o.data, o.rs, o.stable, o.cyc, o.len, e.kind, e.data, e.rs, e.stable, e.cyc, e.len);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL w28_extra: got %0d extra events, expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int a1, a2; ev_t e, o;
    send_byte(8'h41, 1'b1, 1'b1, a1);
    iData = 8'h42;
    push_byte(a1, 8'h41, 1'b1);
    a2 = a1 + 2079;
    push_byte(a2, 8'h42, 1'b1);
    while (cyc < a1 + 2078) @(negedge Clock);
    tests++;
    if (oDone !== 1'b1 || oReady !== 1'b1) begin
      fails++; $display("FAIL b2b_done_cycle: got done=%b rdy=%b, expected 1 1", oDone, oReady);
    end
    while (cyc < a2) @(negedge Clock);
    iValid = 1'b0;
    tests++;
    if (oReady !== 1'b0 || oLCD_Data !== 4'h4) begin
      fails++; $display("FAIL b2b_second_accept: got rdy=%b d=%h, expected rdy=0 d=4", oReady, oLCD_Data);
    end
    run_until(a2 + 2078);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL b2b_event: got none, expected kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL b2b_event: got k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d, expected k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d",
                   o.kind, o.data, o.rs, o.stable, o.cyc, o.len, e.kind, e.data, e.rs, e.stable, e.cyc, e.len);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: got %0d extra events, expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_ignore_busy;
    int a; ev_t e, o;
    send_byte(8'h0C, 1'b0, 1'b0, a);
    push_byte(a, 8'h0C, 1'b0);
    while (cyc < a + 30) @(negedge Clock);
    tests++;
    if (oReady !== 1'b0) begin fails++; $display("FAIL ign_busy_ready: got %b, expected 0", oReady); end
    iData = 8'hFF; iRegisterSelect = 1'b1; iValid = 1'b1;
    @(negedge Clock);
    iValid = 1'b0;
    run_until(a + 2078);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL ign_event: got none, expected kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL ign_event: got k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d, expected k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d",
                   o.kind, o.data, o.rs, o.stable, o.cyc, o.len, e.kind, e.data, e.rs, e.stable, e.cyc, e.len);
        end
      end
    end
    repeat (5) @(negedge Clock);
    #1;
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL ign_extra: got %0d extra events, expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_clear_cmd;
    int a; ev_t e, o;
    send_byte(8'h01, 1'b0, 1'b0, a);
    push_byte(a, 8'h01, 1'b0);
    run_until(a + 78 + exp_wait(8'h01, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL clr_event: got none, expected kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL clr_event: got k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d, expected k=%0d d=%h rs=%b st=%b cyc=%0d len=%0d",
                   o.kind, o.data, o.rs, o.stable, o.cyc, o.len, e.kind, e.data, e.rs, e.stable, e.cyc, e.len);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_byte;
    int a, ndone;
    send_byte(8'h28, 1'b1, 1'b0, a);
    while (cyc < a + 5) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (oLCD_Enabled !== 1'b0 || oLCD_Data !== 4'd0 || oLCD_RegisterSelect !== 1'b0 || oReady !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got e=%b d=%h rs=%b rdy=%b, expected 0 0 0 0",
               oLCD_Enabled, oLCD_Data, oLCD_RegisterSelect, oReady);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    tests++;
    if (oReady !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b, expected 1", oReady); end
    run_until(a + 2200);
    ndone = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == 2'd1) ndone++;
    tests++;
    if (ndone != 0) begin fails++; $display("FAIL mid_reset_no_done: got %0d done pulses, expected 0", ndone); end
    obs_q.delete();
  endtask

  initial begin
    test_reset;
    test_write_28;
    test_back_to_back;
    test_ignore_busy;
    test_clear_cmd;
    test_reset_mid_byte;
    tests++;
    if (oLCD_ReadWrite !== 1'b0) begin fails++; $display("FAIL rw_tied: got %b, expected 0", oLCD_ReadWrite); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
